axi_ram_responder: RTL
======================

Name: axi_ram_responder

Overview:
- AXI3 slave/responder: the memory-side counterpart to the core's AXI initiator (instruction/data MMU).
- Backs a single-port, word-organised RAM array; serves single-beat and burst reads/writes, one transaction at a time.
- Used as the simulation/FPGA main-memory endpoint behind the core's AXI bus; echoes IDs, reports OKAY/SLVERR.

Parameters:
ADDR_WIDTH, 16, byte-address bits decoded into the RAM; higher address bits ignored (aliasing)
ID_WIDTH, 4, width of AXI ID fields
MEM_WORDS, 2**(ADDR_WIDTH-2), RAM depth in 32-bit words

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
awid  in  ID_WIDTH  write address ID
awaddr  in  32  write byte address
awlen  in  8  beats minus 1
awburst  in  2  00 FIXED, 01 INCR, 10 WRAP (unsupported)
awvalid  in  1  AW valid
awready  out  1  AW accept
wdata  in  32  write data
wstrb  in  4  byte enables
wlast  in  1  last write beat
wvalid  in  1  W valid
wready  out  1  W accept
bid  out  ID_WIDTH  echoed awid
bresp  out  2  00 OKAY, 10 SLVERR
bvalid  out  1  B valid
bready  in  1  B accept
arid  in  ID_WIDTH  read address ID
araddr  in  32  read byte address
arlen  in  8  beats minus 1
arburst  in  2  burst type, encoding as awburst
arvalid  in  1  AR valid
arready  out  1  AR accept
rid  out  ID_WIDTH  echoed arid
rdata  out  32  read data
rresp  out  2  00 OKAY, 10 SLVERR
rlast  out  1  last read beat
rvalid  out  1  R valid
rready  in  1  R accept

Behaviour:
- Reset: state IDLE. All valid/ready outputs 0, bid=rid=0, bresp=rresp=0, rdata=0, rlast=0, last_grant=WRITE. RAM contents not reset. rst mid-burst aborts immediately; no further beats or responses are issued.
- FSM states: IDLE, RD, WR, WRESP.
- IDLE: arready/awready are combinational, high only in IDLE. Read granted if arvalid and (!awvalid or last_grant==WRITE); otherwise write granted if awvalid. The non-granted ready is 0. On handshake, latch id, word address addr[ADDR_WIDTH-1:2], len, burst; beat counter=0; last_grant updated.
- AR handshake -> RD. rdata is loaded from RAM at the latched address; rvalid=1 and rlast=(len==0) on the next cycle. First-beat latency is 1 cycle after the AR handshake.
- RD: on each rvalid&&rready, counter++ and address advances (INCR +1 word, wraps modulo MEM_WORDS; FIXED holds), and rdata reloads in the same edge, giving one beat per cycle. rlast=1 exactly on beat len. Handshake on the rlast beat -> IDLE with rvalid=0. rdata/rlast are held stable while rvalid&&!rready.
- AW handshake -> WR. wready=1 throughout WR. Each wvalid&&wready writes wdata byte lanes where wstrb=1; wstrb=0 writes nothing.
- WR exits to WRESP when the beat with counter==len is accepted, or earlier if wlast=1. Early wlast (counter<len), or counter==len without wlast, sets bresp=SLVERR; writes already done are kept.
- WRESP: bvalid=1, bid=latched id. Hold until bready -> IDLE.
- burst==2'b10 (WRAP) or 2'b11: transaction is accepted with no RAM access. Read returns len+1 beats of rdata=0, rresp=SLVERR. Write consumes beats without writing and responds bresp=SLVERR.
- W beats arriving before the AW handshake are not accepted (wready=0 outside WR).

Optional Feature:
- Macro: AXI_RAM_WAIT_EN.
- Defined: every transaction inserts 3 extra stall cycles. In RD, rvalid rises 4 cycles after the AR handshake. In WR, wready stays 0 for the first 3 cycles. This exercises the initiator's wait handling.
- Undefined: latencies exactly as in Behaviour.

Test Plan:
- Single write awaddr=0x100, awburst=INCR, awlen=0, wdata=0xDEADBEEF, wstrb=0xF, wlast=1 -> bvalid next cycle, bresp=00, bid=awid. Read of 0x100 with arlen=0 -> rdata=0xDEADBEEF, rlast=1, rvalid 1 cycle after AR.
- INCR read burst arlen=15 from 0x0 after writing words 0..15 with values i -> 16 back-to-back beats, rdata=0..15, rlast only on beat 16. rready low for 2 cycles mid-burst -> data held, no beat lost.
- Byte strobes: write 0x11223344 with wstrb=0x5 over prior 0xFFFFFFFF -> readback 0xFF22FF44.
- FIXED read burst arlen=3 at 0x20 -> 4 beats, all equal to mem[0x20]. WRAP read -> 4 beats rdata=0, rresp=10.
- awvalid and arvalid both high in the same IDLE cycle, repeated -> grants alternate WRITE/READ. Early wlast on beat 2 of awlen=3 -> bresp=10.
- rst asserted mid read burst -> next cycle rvalid=0, arready=1 if arvalid. With AXI_RAM_WAIT_EN, first rvalid is 4 cycles after AR.

Source files
------------

// File: rtl/axi_ram_responder_if.sv
// rtl/axi_ram_responder_if.sv - AXI3 channel bundle between the core's initiator and the RAM responder
interface axi_ram_responder_if #(
  parameter int ID_WIDTH = 4
);
  logic [ID_WIDTH-1:0] awid;
  logic [31:0]         awaddr;
  logic [7:0]          awlen;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [31:0]         wdata;
  logic [3:0]          wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_WIDTH-1:0] bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_WIDTH-1:0] arid;
  logic [31:0]         araddr;
  logic [7:0]          arlen;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [ID_WIDTH-1:0] rid;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arburst, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input awid, awaddr, awlen, awburst, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/axi_ram_responder.sv
// rtl/axi_ram_responder.sv - AXI3 RAM responder, one transaction at a time; AXI_RAM_WAIT_EN adds 3 stall cycles
module axi_ram_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_WORDS  = 2**(ADDR_WIDTH-2)
) (
  input logic clk,
  input logic rst,
  axi_ram_responder_if.slave axi
);
  localparam int WA = ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AXI_RAM_WAIT_EN
  localparam logic [1:0] STALL = 2'd3;
`else
  localparam logic [1:0] STALL = 2'd0;
`endif

  typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

  state_t              state;
  logic [31:0]         mem [MEM_WORDS];
  logic                last_grant_rd;
  logic [WA-1:0]       addr, addr_nxt, ar_word, aw_word;
  logic [7:0]          len, cnt;
  logic                fixed, unsup;
  logic [1:0]          stall;
  logic [ID_WIDTH-1:0] id_q;
  logic                rd_sel, ar_hs, aw_hs, r_hs, w_hs;
  logic                unused_addr_bits;

  assign ar_word  = axi.araddr[ADDR_WIDTH-1:2];
  assign aw_word  = axi.awaddr[ADDR_WIDTH-1:2];
  assign addr_nxt = fixed ? addr : ((addr == WA'(MEM_WORDS - 1)) ? '0 : addr + 1'b1);
  assign unused_addr_bits = ^{axi.araddr[31:ADDR_WIDTH], axi.araddr[1:0],
                              axi.awaddr[31:ADDR_WIDTH], axi.awaddr[1:0]};

  // Reads win unless the previous grant was also a read and a write is waiting.
  assign rd_sel      = axi.arvalid && (!axi.awvalid || !last_grant_rd);
  assign axi.arready = !rst && (state == IDLE) && rd_sel;
  assign axi.awready = !rst && (state == IDLE) && axi.awvalid && !rd_sel;
  assign axi.wready  = !rst && (state == WR) && (stall == 2'd0);

  assign ar_hs = axi.arvalid && axi.arready;
  assign aw_hs = axi.awvalid && axi.awready;
  assign r_hs  = axi.rvalid && axi.rready;
  assign w_hs  = axi.wvalid && axi.wready;

  always_ff @(posedge clk) begin
    if (w_hs && !unsup) begin
      for (int b = 0; b < 4; b++) begin
        if (axi.wstrb[b]) mem[addr][8*b +: 8] <= axi.wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_grant_rd <= 1'b0;
      addr          <= '0;
      len           <= '0;
      cnt           <= '0;
      fixed         <= 1'b0;
      unsup         <= 1'b0;
      stall         <= '0;
      id_q          <= '0;
      axi.rvalid    <= 1'b0;
      axi.rdata     <= '0;
      axi.rresp     <= RESP_OKAY;
      axi.rlast     <= 1'b0;
      axi.rid       <= '0;
      axi.bvalid    <= 1'b0;
      axi.bresp     <= RESP_OKAY;
      axi.bid       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ar_hs) begin
            state         <= RD;
            last_grant_rd <= 1'b1;
            axi.rid       <= axi.arid;
            addr          <= ar_word;
            len           <= axi.arlen;
            cnt           <= '0;
            fixed         <= (axi.arburst == 2'b00);
            unsup         <= axi.arburst[1];
            stall         <= STALL;
            if (STALL == 2'd0) begin
              axi.rvalid <= 1'b1;
              axi.rdata  <= axi.arburst[1] ? '0 : mem[ar_word];
              axi.rresp  <= axi.arburst[1] ? RESP_SLVERR : RESP_OKAY;
              axi.rlast  <= (axi.arlen == 8'd0);
            end
          end else if (aw_hs) begin
            state         <= WR;
            last_grant_rd <= 1'b0;
            id_q          <= axi.awid;
            addr          <= aw_word;
            len           <= axi.awlen;
            cnt           <= '0;
            fixed         <= (axi.awburst == 2'b00);
            unsup         <= axi.awburst[1];
            stall         <= STALL;
          end
        end
        RD: begin
          if (stall != 2'd0) begin
            stall <= stall - 2'd1;
            if (stall == 2'd1) begin
              axi.rvalid <= 1'b1;
              axi.rdata  <= unsup ? '0 : mem[addr];
              axi.rresp  <= unsup ? RESP_SLVERR : RESP_OKAY;
              axi.rlast  <= (len == 8'd0);
            end
          end else if (r_hs) begin
            if (axi.rlast) begin
              state      <= IDLE;
              axi.rvalid <= 1'b0;
              axi.rlast  <= 1'b0;
            end else begin
              cnt       <= cnt + 8'd1;
              addr      <= addr_nxt;
              axi.rdata <= unsup ? '0 : mem[addr_nxt];
              axi.rlast <= (cnt + 8'd1 == len);
            end
          end
        end
        WR: begin
          if (stall != 2'd0) begin
            stall <= stall - 2'd1;
          end else if (w_hs) begin
            cnt  <= cnt + 8'd1;
            addr <= addr_nxt;
            // A burst ends on wlast or on its final beat; any disagreement between the two is an error.
            if (axi.wlast || cnt == len) begin
              state      <= WRESP;
              axi.bvalid <= 1'b1;
              axi.bid    <= id_q;
              axi.bresp  <= (unsup || !(axi.wlast && cnt == len)) ? RESP_SLVERR : RESP_OKAY;
            end
          end
        end
        WRESP: begin
          if (axi.bready) begin
            state      <= IDLE;
            axi.bvalid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
